// File: rtl/store_buffer_pkg.sv
// Shared constants, entry type and lane helpers for the store buffer slice.
package store_buffer_pkg;

  localparam int StoreBufDepth = 4;
  localparam int SelW          = 4;
  localparam int WordAddrLo    = 2;
  localparam int WordAddrW     = 32 - WordAddrLo;
  localparam logic RstActiveLow = 1'b0;

  typedef struct packed {
    logic [WordAddrW-1:0] addr;
    logic [31:0]          data;
    logic [SelW-1:0]      sel;
  } sb_entry_t;

  // Expand byte selects into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [SelW-1:0] sel);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < SelW; l++) begin
      m[8*l +: 8] = {8{sel[l]}};
    end
    return m;
  endfunction

  // Overwrite the lanes of old_data selected by sel with new_data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                               input logic [31:0] new_data,
                                               input logic [SelW-1:0] sel);
    logic [31:0] m;
    m = lane_mask(sel);
    return (old_data & ~m) | (new_data & m);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Per-lane newest-wins forwarding of buffered store bytes to a load lookup.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = StoreBufDepth,
  parameter int PTR_W = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      head,
  input  logic [PTR_W:0]        count,
  input  logic                  ld_valid,
  input  logic [WordAddrW-1:0]  ld_word,
  input  logic [SelW-1:0]       ld_sel,
  output logic [31:0]           fwd_data,
  output logic [SelW-1:0]       fwd_mask,
  output logic                  hit,
  output logic                  partial
);

  logic [SelW-1:0]  cov;
  logic [31:0]      bytes;
  logic [PTR_W:0]   age;
  logic [PTR_W-1:0] idx;

  // Walk live entries oldest to newest so later matches override earlier lanes.
  always_comb begin
    cov   = '0;
    bytes = '0;
    age   = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age = (PTR_W+1)'(k);
      idx = head + age[PTR_W-1:0];
      if ((age < count) && (entries[idx].addr == ld_word)) begin
        for (int l = 0; l < SelW; l++) begin
          if (entries[idx].sel[l]) begin
            cov[l]          = 1'b1;
            bytes[8*l +: 8] = entries[idx].data[8*l +: 8];
          end
        end
      end
    end
    fwd_mask = ld_valid ? (cov & ld_sel) : '0;
    fwd_data = bytes & lane_mask(fwd_mask);
    hit      = (fwd_mask == ld_sel) && (ld_sel != '0);
    partial  = (fwd_mask != '0) && !hit;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order retirement to ram, load forwarding,
// and coalescing of back-to-back stores to the same word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = StoreBufDepth,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  input  logic [31:0]     st_addr,
  input  logic [31:0]     st_data,
  input  logic [SelW-1:0] st_sel,
  output logic            st_ready,
  input  logic            ld_valid,
  input  logic [31:0]     ld_addr,
  input  logic [SelW-1:0] ld_sel,
  output logic [31:0]     ld_fwd_data,
  output logic [SelW-1:0] ld_fwd_mask,
  output logic            ld_hit,
  output logic            ld_partial,
  input  logic            ram_grant,
  output logic            ram_we,
  output logic [31:0]     ram_write_addr,
  output logic [31:0]     ram_write_instr,
  output logic [SelW-1:0] ram_write,
  output logic            empty
);

  sb_entry_t [DEPTH-1:0] ent_q;
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [PTR_W-1:0]      tail_m1;
  logic [PTR_W:0]        count_q;
  logic                  push;
  logic                  coalesce;
  logic                  alloc;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[WordAddrLo-1:0], ld_addr[WordAddrLo-1:0]};

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign ram_we   = !empty && ram_grant;

  assign ram_write_addr  = {ent_q[head_q].addr, {WordAddrLo{1'b0}}};
  assign ram_write_instr = ent_q[head_q].data;
  assign ram_write       = ent_q[head_q].sel;

  // A zero-select store is accepted but leaves the buffer untouched. The
  // youngest entry may absorb a same-word store unless it is retiring now.
  assign tail_m1  = tail_q - PTR_W'(1);
  assign push     = st_valid && st_ready && (st_sel != '0);
  assign coalesce = !empty
                    && (ent_q[tail_m1].addr == st_addr[31:WordAddrLo])
                    && !(ram_we && (head_q == tail_m1));
  assign alloc    = push && !coalesce;

  // Pointer and occupancy tracking; only control state is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActiveLow) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc)  tail_q <= tail_q + PTR_W'(1);
      if (ram_we) head_q <= head_q + PTR_W'(1);
      case ({alloc, ram_we})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload: allocate at tail or merge lanes into the youngest entry.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_q[tail_q] <= '{addr: st_addr[31:WordAddrLo], data: st_data, sel: st_sel};
    end else if (push) begin
      ent_q[tail_m1].data <= merge_lanes(ent_q[tail_m1].data, st_data, st_sel);
      ent_q[tail_m1].sel  <= ent_q[tail_m1].sel | st_sel;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries  (ent_q),
    .head     (head_q),
    .count    (count_q),
    .ld_valid (ld_valid),
    .ld_word  (ld_addr[31:WordAddrLo]),
    .ld_sel   (ld_sel),
    .fwd_data (ld_fwd_data),
    .fwd_mask (ld_fwd_mask),
    .hit      (ld_hit),
    .partial  (ld_partial)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model plus directed vectors.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_sel;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_mask;
  logic        ld_hit;
  logic        ld_partial;
  logic        ram_grant;
  logic        ram_we;
  logic [31:0] ram_write_addr;
  logic [31:0] ram_write_instr;
  logic [3:0]  ram_write;
  logic        empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sel(ld_sel),
    .ld_fwd_data(ld_fwd_data), .ld_fwd_mask(ld_fwd_mask),
    .ld_hit(ld_hit), .ld_partial(ld_partial),
    .ram_grant(ram_grant), .ram_we(ram_we), .ram_write_addr(ram_write_addr),
    .ram_write_instr(ram_write_instr), .ram_write(ram_write), .empty(empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending word stores.
  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t q[$];
  bit   m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else begin
      m_pop = (q.size() > 0) && ram_grant;
      if (st_valid && (q.size() < DEPTH) && (st_sel != 4'h0)) begin
        if ((q.size() > 0) && (q[q.size()-1].a == st_addr[31:2]) && !(m_pop && q.size() == 1)) begin
          for (int l = 0; l < 4; l++)
            if (st_sel[l]) q[q.size()-1].d[8*l +: 8] = st_data[8*l +: 8];
          q[q.size()-1].s = q[q.size()-1].s | st_sel;
        end else begin
          q.push_back('{a: st_addr[31:2], d: st_data, s: st_sel});
        end
      end
      if (m_pop) void'(q.pop_front());
    end
  end

  logic [3:0]  e_cov, e_mask;
  logic [31:0] e_bytes, e_data;
  logic        e_hit, e_part, e_we;

  // Compare every output against the model mid-cycle while out of reset.
  always @(negedge clk) begin
    if (rst) begin
      e_we = (q.size() > 0) && ram_grant;
      chk("st_ready", st_ready, (q.size() < DEPTH));
      chk("empty", empty, (q.size() == 0));
      chk("ram_we", ram_we, e_we);
      if (e_we) begin
        chk("ram_addr", ram_write_addr, {q[0].a, 2'b00});
        chk("ram_data", ram_write_instr, q[0].d);
        chk("ram_sel", ram_write, q[0].s);
      end
      e_cov = 4'h0;
      e_bytes = 32'h0;
      foreach (q[i]) begin
        if (q[i].a == ld_addr[31:2]) begin
          for (int l = 0; l < 4; l++) begin
            if (q[i].s[l]) begin
              e_cov[l] = 1'b1;
              e_bytes[8*l +: 8] = q[i].d[8*l +: 8];
            end
          end
        end
      end
      e_mask = ld_valid ? (e_cov & ld_sel) : 4'h0;
      e_data = 32'h0;
      for (int l = 0; l < 4; l++)
        if (e_mask[l]) e_data[8*l +: 8] = e_bytes[8*l +: 8];
      e_hit  = (e_mask == ld_sel) && (ld_sel != 4'h0);
      e_part = (e_mask != 4'h0) && !e_hit;
      chk("fwd_mask", ld_fwd_mask, e_mask);
      chk("fwd_data", ld_fwd_data, e_data);
      chk("ld_hit", ld_hit, e_hit);
      chk("ld_partial", ld_partial, e_part);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sel   = s;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    ram_grant = 1'b1;
    for (int i = 0; i < 16 && !empty; i++) tick();
    ram_grant = 1'b0;
    chk("drain_empty", empty, 1'b1);
  endtask

  logic [31:0] last_wr;
  bit          seen_wr;

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_sel = '0; ram_grant = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_hit", ld_hit, 1'b0);
    chk("rst_partial", ld_partial, 1'b0);
    chk("rst_mask", ld_fwd_mask, 4'h0);
    rst = 1'b1;
    tick();

    // Fill with grant low, then drain in order.
    for (int k = 0; k < 4; k++) store(32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'hF);
    st_valid = 1'b1; st_addr = 32'h110; st_data = 32'hDEAD_BEEF; st_sel = 4'hF;
    @(negedge clk);
    chk("full_ready", st_ready, 1'b0);
    tick(); tick();
    st_valid = 1'b0;
    ram_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_we", ram_we, 1'b1);
      chk("drain_addr", ram_write_addr, 32'h100 + 32'(4*k));
      tick();
    end
    ram_grant = 1'b0;
    chk("drained_empty", empty, 1'b1);

    // Coalesce two stores to one word.
    store(32'h200, 32'h0000_00AA, 4'b0001);
    store(32'h200, 32'h0000_BB00, 4'b0010);
    @(negedge clk);
    chk("coal_data", ram_write_instr, 32'h0000_BBAA);
    chk("coal_sel", ram_write, 4'b0011);
    chk("coal_addr", ram_write_addr, 32'h200);
    tick();
    ram_grant = 1'b1;
    tick();
    ram_grant = 1'b0;
    chk("coal_one_entry", empty, 1'b1);

    // No coalesce into the entry that retires this cycle.
    store(32'h900, 32'h0000_0011, 4'b0001);
    st_valid = 1'b1; st_addr = 32'h900; st_data = 32'h0000_2200; st_sel = 4'b0010;
    ram_grant = 1'b1;
    tick();
    st_valid = 1'b0; ram_grant = 1'b0;
    @(negedge clk);
    chk("nocoal_empty", empty, 1'b0);
    chk("nocoal_sel", ram_write, 4'b0010);
    chk("nocoal_data", ram_write_instr, 32'h0000_2200);
    tick();
    drain();

    // Zero-select store is a no-op.
    store(32'h700, 32'h1234_5678, 4'h0);
    chk("sel0_empty", empty, 1'b1);

    // Newest-wins forwarding, including while entries retire.
    store(32'h300, 32'h1122_3344, 4'hF);
    store(32'h304, 32'h5566_7788, 4'hF);
    store(32'h300, 32'h0000_00FF, 4'h1);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_sel = 4'hF;
    @(negedge clk);
    chk("fwd_newest", ld_fwd_data, 32'h1122_33FF);
    chk("fwd_hit", ld_hit, 1'b1);
    chk("fwd_part", ld_partial, 1'b0);
    tick();
    drain();
    ld_valid = 1'b0;

    // Partial coverage and miss.
    store(32'h400, 32'h0000_CAFE, 4'b0011);
    ld_valid = 1'b1; ld_addr = 32'h400; ld_sel = 4'hF;
    @(negedge clk);
    chk("part_flag", ld_partial, 1'b1);
    chk("part_hit", ld_hit, 1'b0);
    chk("part_mask", ld_fwd_mask, 4'b0011);
    chk("part_data", ld_fwd_data, 32'h0000_CAFE);
    tick();
    ld_addr = 32'h404;
    @(negedge clk);
    chk("miss_mask", ld_fwd_mask, 4'h0);
    chk("miss_part", ld_partial, 1'b0);
    tick();
    ld_valid = 1'b0;
    drain();

    // Full with a simultaneous pop: store waits one cycle.
    for (int k = 0; k < 4; k++) store(32'h500 + 32'(8*k), 32'hB000_0000 + 32'(k), 4'hF);
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'hC0DE_0600; st_sel = 4'hF;
    ram_grant = 1'b1;
    @(negedge clk);
    chk("fullpop_ready", st_ready, 1'b0);
    chk("fullpop_we", ram_we, 1'b1);
    tick();
    @(negedge clk);
    chk("fullpop_ready2", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    seen_wr = 1'b0;
    last_wr = '0;
    for (int i = 0; i < 20 && !empty; i++) begin
      @(negedge clk);
      if (ram_we) begin
        last_wr = ram_write_addr;
        seen_wr = 1'b1;
      end
      tick();
    end
    ram_grant = 1'b0;
    chk("fullpop_empty", empty, 1'b1);
    chk("fullpop_seen", seen_wr, 1'b1);
    chk("fullpop_last", last_wr, 32'h600);

    // Reset mid-stream with three pending stores.
    store(32'h800, 32'h1, 4'hF);
    store(32'h804, 32'h2, 4'hF);
    store(32'h808, 32'h3, 4'hF);
    chk("pre_rst_empty", empty, 1'b0);
    #2;
    rst = 1'b0;
    ram_grant = 1'b1;
    @(negedge clk);
    chk("in_rst_we", ram_we, 1'b0);
    chk("in_rst_empty", empty, 1'b1);
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", empty, 1'b1);
    chk("post_rst_we", ram_we, 1'b0);
    chk("post_rst_ready", st_ready, 1'b1);
    tick();
    ram_grant = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
